test_exit_monitor: RTL and testbench
====================================

Name: test_exit_monitor

Overview:
- Hardware self-check block that consumes the architectural-state outputs of cpu_top: ecall, x17 (a7), x10 (a0) and x3 (gp).
- Drives the core's reset, runs one test program, and detects the exit ecall (a7 == EXIT_CODE).
- Samples a0 after a settle window and reports pass, fail or timeout with cycle and retired-instruction counts.
- Lets the self-checking test flow run on FPGA and in simulation without a testbench-side polling loop.

Parameters:
- TIMEOUT_CYCLES, 1000, RUN-state cycles allowed before a timeout is declared.
- EXIT_CODE, 93, a7 value that marks the exit ecall.
- SETTLE_CYCLES, 2, cycles between exit detection and sampling a0 (range 1..15).
- RST_CYCLES, 3, cycles core_rst is held high after start (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse that begins a test run.
- ecall  in  1  core ecall indication, qualified in the WB stage.
- retire  in  1  one pulse per retired instruction.
- a7  in  32  core x17.
- a0  in  32  core x10.
- gp  in  32  core x3.
- core_rst  out  1  active-high reset to cpu_top.
- busy  out  1  high in RESET_CORE, RUN and SETTLE.
- done  out  1  high in DONE.
- pass  out  1  result flag, sticky until the next start.
- fail  out  1  result flag, sticky until the next start.
- timeout  out  1  result flag, sticky until the next start.
- fail_code  out  32  a0 sampled at the end of SETTLE.
- cycle_count  out  32  RUN + SETTLE cycles; saturates at 0xFFFFFFFF.
- instret_count  out  32  retire pulses seen in RUN + SETTLE; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state goes to IDLE.
  - core_rst = 1.
  - busy, done, pass, fail and timeout = 0.
  - fail_code, cycle_count and instret_count = 0.
  - The internal counter is cleared.
  - rst overrides every other input in every state, including mid-run.
- States: IDLE, RESET_CORE, RUN, SETTLE, DONE. All outputs are registered.
- IDLE:
  - core_rst = 1.
  - start -> RESET_CORE. On the same edge, clear all counters, all flags and fail_code.
- RESET_CORE:
  - core_rst = 1 for exactly RST_CYCLES cycles, then go to RUN.
  - core_rst is 0 from the first RUN cycle onward.
  - start is ignored.
- RUN:
  - cycle_count increments every cycle.
  - instret_count increments on each retire.
  - Trigger = ecall && (a7 == EXIT_CODE), compared on the full 32 bits.
  - Trigger -> SETTLE. The settle counter loads SETTLE_CYCLES.
  - No trigger and cycle_count == TIMEOUT_CYCLES-1 -> DONE with timeout = 1. cycle_count ends at TIMEOUT_CYCLES.
  - Trigger and timeout on the same cycle: the trigger wins, no timeout.
  - An ecall whose a7 != EXIT_CODE is ignored.
  - start is ignored.
- SETTLE:
  - The core keeps running (core_rst = 0).
  - Counters continue to update.
  - Further ecalls are ignored.
  - After SETTLE_CYCLES cycles, sample a0 into fail_code and go to DONE.
  - pass = (a0 == 0); fail = (a0 != 0).
- DONE:
  - core_rst = 1, freezing the core.
  - Counters and flags hold.
  - start -> RESET_CORE, clearing counters and flags as in IDLE.
- Exactly one of pass, fail or timeout is set in DONE; none is set outside DONE after a start.

Optional Feature:
- Macro: TEST_EXIT_MONITOR_PROGRESS_EN.
- When defined:
  - Adds output last_gp [31:0].
  - last_gp registers gp every RUN and SETTLE cycle, and holds in DONE.
  - last_gp is cleared by reset and by start.
  - On timeout it reports the test number that hung.
- When undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset and start:
  - Stimulus: hold rst = 0 for 2 cycles with random inputs.
  - Required: core_rst = 1, every other output = 0, state IDLE.
  - Stimulus: release rst, then pulse start.
  - Required: core_rst stays high for exactly 3 cycles, then goes to 0; busy = 1.
- Pass:
  - Stimulus: in RUN cycle 20, ecall = 1, a7 = 93, a0 = 0; 15 retire pulses before it.
  - Required: done rises 2 cycles later with pass = 1, fail_code = 0, cycle_count = 22, instret_count = 15, core_rst = 1.
- Fail with late a0:
  - Stimulus: trigger with a0 = 0, then a0 = 7 during SETTLE.
  - Required: fail = 1, pass = 0, fail_code = 7.
- Wrong exit code and timeout:
  - Stimulus: ecall with a7 = 64 at cycle 5, then no further ecall.
  - Required: no SETTLE entry; timeout = 1 and cycle_count = 1000 at done.
  - With PROGRESS_EN: last_gp equals the gp value driven on the last RUN cycle.
- Simultaneous trigger and timeout:
  - Stimulus: trigger on RUN cycle 1000.
  - Required: SETTLE is taken, the result is pass or fail, timeout = 0.
- Reset mid-run and restart:
  - Stimulus: rst = 0 during SETTLE.
  - Required: IDLE on the next edge, all outputs cleared, core_rst = 1.
  - Stimulus: pulse start from DONE after a fail.
  - Required: flags clear and the run restarts with counts from 0.

Source files
------------

// File: rtl/test_exit_monitor.sv
// Self-check sequencer for cpu_top: resets the core, runs one program, detects the exit ecall
// and reports pass/fail/timeout with cycle and retired-instruction counts.
// Optional macro TEST_EXIT_MONITOR_PROGRESS_EN adds the last_gp progress output.
module test_exit_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned EXIT_CODE      = 93,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned RST_CYCLES     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ecall,
  input  logic        retire,
  input  logic [31:0] a7,
  input  logic [31:0] a0,
  input  logic [31:0] gp,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] fail_code,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
  ,
  output logic [31:0] last_gp
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_CORE = 3'd1,
    RUN        = 3'd2,
    SETTLE     = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            core_rst_nxt, busy_nxt, done_nxt;
  logic            pass_nxt, fail_nxt, timeout_nxt;
  logic [DW-1:0]   fail_code_nxt, cycle_nxt, instret_nxt;
  logic [DW-1:0]   cycle_inc, instret_inc;
  logic            exit_hit, run_expired, settle_last;

`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
  logic [DW-1:0]   last_gp_nxt;
`else
  logic            unused_gp;
  assign unused_gp = ^gp;
`endif

  assign exit_hit    = ecall && (a7 == DW'(EXIT_CODE));
  assign run_expired = (cycle_count == DW'(TIMEOUT_CYCLES - 1));
  assign settle_last = (cnt <= CW'(1));
  // Saturating increments so long runs never wrap back to small counts
  assign cycle_inc   = (cycle_count == '1) ? cycle_count : cycle_count + DW'(1);
  assign instret_inc = (instret_count == '1) ? instret_count : instret_count + DW'(1);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      core_rst      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      fail_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
      last_gp       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      core_rst      <= core_rst_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      pass          <= pass_nxt;
      fail          <= fail_nxt;
      timeout       <= timeout_nxt;
      fail_code     <= fail_code_nxt;
      cycle_count   <= cycle_nxt;
      instret_count <= instret_nxt;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
      last_gp       <= last_gp_nxt;
`endif
    end
  end

  // Next-state; a trigger beats the timeout on the same cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = RESET_CORE;
      RESET_CORE: if (cnt == '0) state_nxt = RUN;
      RUN: begin
        if (exit_hit)         state_nxt = SETTLE;
        else if (run_expired) state_nxt = DONE;
      end
      SETTLE:     if (settle_last) state_nxt = DONE;
      DONE:       if (start) state_nxt = RESET_CORE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values for counters, flags and status outputs
  always_comb begin
    cnt_nxt       = cnt;
    cycle_nxt     = cycle_count;
    instret_nxt   = instret_count;
    pass_nxt      = pass;
    fail_nxt      = fail;
    timeout_nxt   = timeout;
    fail_code_nxt = fail_code;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
    last_gp_nxt   = last_gp;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          cnt_nxt       = CW'(RST_CYCLES - 1);
          cycle_nxt     = '0;
          instret_nxt   = '0;
          pass_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          timeout_nxt   = 1'b0;
          fail_code_nxt = '0;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
          last_gp_nxt   = '0;
`endif
        end
      end
      RESET_CORE: begin
        if (cnt != '0) cnt_nxt = cnt - CW'(1);
      end
      RUN: begin
        cycle_nxt = cycle_inc;
        if (retire) instret_nxt = instret_inc;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
        last_gp_nxt = gp;
`endif
        if (exit_hit)         cnt_nxt     = CW'(SETTLE_CYCLES);
        else if (run_expired) timeout_nxt = 1'b1;
      end
      SETTLE: begin
        cycle_nxt = cycle_inc;
        if (retire) instret_nxt = instret_inc;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
        last_gp_nxt = gp;
`endif
        if (settle_last) begin
          cnt_nxt       = '0;
          fail_code_nxt = a0;
          pass_nxt      = (a0 == '0);
          fail_nxt      = (a0 != '0);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: ;
    endcase
    core_rst_nxt = !((state_nxt == RUN) || (state_nxt == SETTLE));
    busy_nxt     = (state_nxt == RESET_CORE) || (state_nxt == RUN) || (state_nxt == SETTLE);
    done_nxt     = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_test_exit_monitor.sv
// Scoreboard bench for test_exit_monitor: tests push expected results, a monitor
// pops and compares them whenever done rises.
`timescale 1ns/1ps
module tb_test_exit_monitor;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] fail_code;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
  } result_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ecall = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic [31:0] gp = '0;
  logic        core_rst, busy, done, pass, fail, timeout;
  logic [31:0] fail_code, cycle_count, instret_count;
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
  logic [31:0] last_gp;
`endif

  int checks = 0;
  int errors = 0;
  result_t exp_q[$];

  test_exit_monitor dut (
    .clk(clk), .rst(rst), .start(start), .ecall(ecall), .retire(retire),
    .a7(a7), .a0(a0), .gp(gp),
    .core_rst(core_rst), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_code(fail_code), .cycle_count(cycle_count),
    .instret_count(instret_count)
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
    , .last_gp(last_gp)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: compare the oldest expected result on every rising done
  initial begin : scoreboard
    logic    prev_done;
    result_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev_done !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done got done=1 exp no pending result");
        end else begin
          e = exp_q.pop_front();
          if (pass !== e.pass) begin
            errors++; $display("FAIL sb_pass got=%0b exp=%0b", pass, e.pass);
          end
          checks++;
          if (fail !== e.fail) begin
            errors++; $display("FAIL sb_fail got=%0b exp=%0b", fail, e.fail);
          end
          checks++;
          if (timeout !== e.timeout) begin
            errors++; $display("FAIL sb_timeout got=%0b exp=%0b", timeout, e.timeout);
          end
          checks++;
          if (fail_code !== e.fail_code) begin
            errors++; $display("FAIL sb_fail_code got=%0h exp=%0h", fail_code, e.fail_code);
          end
          checks++;
          if (cycle_count !== e.cycle_count) begin
            errors++; $display("FAIL sb_cycle_count got=%0d exp=%0d", cycle_count, e.cycle_count);
          end
          checks++;
          if (instret_count !== e.instret_count) begin
            errors++; $display("FAIL sb_instret_count got=%0d exp=%0d", instret_count, e.instret_count);
          end
        end
      end
      prev_done = done;
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog got=no finish exp=finish within 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      start = 1'(($urandom) & 1); ecall = 1'(($urandom) & 1); retire = 1'(($urandom) & 1);
      a7 = $urandom; a0 = $urandom; gp = $urandom;
      @(negedge clk);
    end
    checks++;
    if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        fail !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=100000", {core_rst, busy, done, pass, fail, timeout});
    end
    checks++;
    if (fail_code !== 0 || cycle_count !== 0 || instret_count !== 0) begin
      errors++;
      $display("FAIL reset_counts got=%0h/%0d/%0d exp=0/0/0", fail_code, cycle_count, instret_count);
    end
    start = 1'b0; ecall = 1'b0; retire = 1'b0; a7 = '0; a0 = '0; gp = '0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release got=%b%b exp=10", core_rst, busy);
    end
  endtask

  // Pulse start and verify cleared flags and the core reset window
  task automatic do_start();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || timeout !== 1'b0 ||
        cycle_count !== 0 || instret_count !== 0 || fail_code !== 0) begin
      errors++;
      $display("FAIL start_clear got=b%b d%b p%b f%b t%b cc%0d ir%0d fc%0h exp=b1 rest 0",
               busy, done, pass, fail, timeout, cycle_count, instret_count, fail_code);
    end
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
    checks++;
    if (last_gp !== 0) begin
      errors++; $display("FAIL start_last_gp got=%0h exp=0", last_gp);
    end
`endif
    n = 0;
    while (core_rst === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL core_rst_len got=%0d exp=3", n);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL run_busy got=%0b exp=1", busy);
    end
  endtask

  task automatic test_pass();
    result_t e;
    int n;
    do_start();
    e = '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, fail_code: 32'd0,
          cycle_count: 32'd22, instret_count: 32'd15};
    exp_q.push_back(e);
    for (int k = 1; k <= 20; k++) begin
      retire = (k <= 15);
      ecall  = (k == 20);
      a7     = (k == 20) ? 32'd93 : $urandom;
      a0     = '0;
      gp     = 32'(k);
      @(negedge clk);
    end
    ecall = 1'b0; retire = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL pass_latency got=%0d exp=2", n);
    end
    checks++;
    if (core_rst !== 1'b1) begin
      errors++; $display("FAIL pass_core_rst got=%0b exp=1", core_rst);
    end
  endtask

  task automatic test_fail_late_a0();
    result_t e;
    int n, ir;
    logic r1, r2;
    do_start();
    ir = 0;
    r1 = 1'(($urandom) & 1);
    r2 = 1'(($urandom) & 1);
    for (int k = 1; k <= 3; k++) begin
      retire = 1'(($urandom) & 1);
      ir += int'(retire);
      ecall = (k == 3);
      a7 = (k == 3) ? 32'd93 : 32'd17;
      a0 = '0;
      if (k == 3) begin
        e = '{pass: 1'b0, fail: 1'b1, timeout: 1'b0, fail_code: 32'd7,
              cycle_count: 32'd5, instret_count: 32'(ir + int'(r1) + int'(r2))};
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    ecall = 1'b1; a7 = 32'd93; a0 = 32'd7; retire = r1;
    @(negedge clk);
    ecall = 1'b0; retire = r2;
    @(negedge clk);
    retire = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL fail_latency got=%0d exp=0", n);
    end
    a0 = '0;
  endtask

  task automatic test_timeout();
    result_t e;
    int ir;
    logic [31:0] last;
    do_start();
    ir = 0;
    last = '0;
    for (int k = 1; k <= 1000; k++) begin
      retire = 1'(($urandom) & 1);
      ir += int'(retire);
      ecall = (k == 5);
      a7 = (k == 5) ? 32'd64 : $urandom;
      a0 = 32'd3;
      gp = $urandom;
      last = gp;
      if (k == 1000) begin
        e = '{pass: 1'b0, fail: 1'b0, timeout: 1'b1, fail_code: 32'd0,
              cycle_count: 32'd1000, instret_count: 32'(ir)};
        exp_q.push_back(e);
      end
      @(negedge clk);
      if (k == 10 || k == 999) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL early_done k=%0d got=d%0b b%0b exp=d0 b1", k, done, busy);
        end
      end
    end
    ecall = 1'b0; retire = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL timeout_done got=%0b exp=1", done);
    end
`ifdef TEST_EXIT_MONITOR_PROGRESS_EN
    checks++;
    if (last_gp !== last) begin
      errors++; $display("FAIL last_gp got=%0h exp=%0h", last_gp, last);
    end
`else
    last = '0;
`endif
    a0 = '0;
  endtask

  task automatic test_simultaneous();
    result_t e;
    int n, ir;
    do_start();
    ir = 0;
    for (int k = 1; k <= 1000; k++) begin
      retire = 1'(($urandom) & 1);
      ir += int'(retire);
      ecall = (k == 1000);
      a7 = 32'd93;
      a0 = '0;
      if (k == 1000) begin
        e = '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, fail_code: 32'd0,
              cycle_count: 32'd1002, instret_count: 32'(ir)};
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    ecall = 1'b0; retire = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL simul_settle got=d%0b b%0b exp=d0 b1", done, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL simul_latency got=%0d exp=2", n);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start();
    ecall = 1'b0; retire = 1'b1; a7 = 32'd93; a0 = 32'd9;
    @(negedge clk);
    ecall = 1'b1;
    @(negedge clk);
    ecall = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; retire = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        fail !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags got=%b exp=100000", {core_rst, busy, done, pass, fail, timeout});
    end
    checks++;
    if (fail_code !== 0 || cycle_count !== 0 || instret_count !== 0) begin
      errors++;
      $display("FAIL midrst_counts got=%0h/%0d/%0d exp=0/0/0", fail_code, cycle_count, instret_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got=d%0b b%0b exp=d0 b0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    result_t e;
    do_start();
    e = '{pass: 1'b0, fail: 1'b1, timeout: 1'b0, fail_code: 32'h8000_0001,
          cycle_count: 32'd3, instret_count: 32'd3};
    exp_q.push_back(e);
    ecall = 1'b1; a7 = 32'd93; a0 = 32'h8000_0001; retire = 1'b1;
    @(negedge clk);
    ecall = 1'b0;
    repeat (2) @(negedge clk);
    retire = 1'b0;
    checks++;
    if (done !== 1'b1 || fail_code !== 32'h8000_0001) begin
      errors++; $display("FAIL b2b_done got=d%0b fc%0h exp=d1 fc80000001", done, fail_code);
    end
    a0 = '0;
  endtask

  initial begin : main
    test_reset();
    test_pass();
    test_fail_late_a0();
    test_timeout();
    test_simultaneous();
    test_reset_mid_run();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
